stream_demux1to2: RTL and testbench

- Registered 1-to-2 stream demultiplexer; the inverse of the team's mux2to1 datapath.
- Accepts a single valid/ready input stream and routes whole packets to one of two output streams.
- Route is chosen by i_sel, sampled on the first beat of each packet and held until the i_last beat.
- Each output has its own one-entry register slot; latency is 1 cycle, with full throughput when downstream is ready.

---
 rtl/stream_demux1to2_if.sv | 35 +++
 rtl/stream_demux1to2.sv | 136 +++++++++++++
 tb/tb_stream_demux1to2.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/stream_demux1to2_if.sv
// rtl/stream_demux1to2_if.sv - handshake bundle for the 1-to-2 stream demultiplexer
//
// Purpose: groups the input stream, the destination select and both output
// streams of stream_demux1to2 into one interface.
// Modports:
//   slave  - the demux: consumes i_valid/i_data/i_last/i_sel/i_ready_0/i_ready_1,
//            drives o_ready/o_valid_k/o_data_k/o_last_k
//   master - the environment around the demux (upstream source and both sinks)
interface stream_demux1to2_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_last;
  logic                  i_sel;
  logic                  o_valid_0;
  logic                  o_valid_1;
  logic                  i_ready_0;
  logic                  i_ready_1;
  logic [DATA_WIDTH-1:0] o_data_0;
  logic [DATA_WIDTH-1:0] o_data_1;
  logic                  o_last_0;
  logic                  o_last_1;

  modport slave (
    input  i_valid, i_data, i_last, i_sel, i_ready_0, i_ready_1,
    output o_ready, o_valid_0, o_valid_1, o_data_0, o_data_1, o_last_0, o_last_1
  );

  modport master (
    output i_valid, i_data, i_last, i_sel, i_ready_0, i_ready_1,
    input  o_ready, o_valid_0, o_valid_1, o_data_0, o_data_1, o_last_0, o_last_1
  );
endinterface

// File: rtl/stream_demux1to2.sv
// rtl/stream_demux1to2.sv - registered 1-to-2 packet stream demultiplexer
//
// Purpose: routes whole packets from one valid/ready input stream to one of
// two outputs. The destination is taken from i_sel on a packet's first beat
// and locked until its i_last beat. Each output has a one-entry register slot
// (1-cycle latency, full throughput while the downstream is ready).
// Optional feature macro: STREAM_DEMUX_CNT_EN enables the per-output
// completed-packet counters; without it o_cnt_0/o_cnt_1 are tied to 0.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst   - asynchronous active-high reset
//   bus     - stream_demux1to2_if.slave: input stream, i_sel, both output streams
//   o_busy  - high while inside a multi-beat packet
//   o_cnt_0 - packets completed on output 0 (feature only)
//   o_cnt_1 - packets completed on output 1 (feature only)
module stream_demux1to2 #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  stream_demux1to2_if.slave     bus,
  output logic                  o_busy,
  output logic [CNT_WIDTH-1:0]  o_cnt_0,
  output logic [CNT_WIDTH-1:0]  o_cnt_1
);

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t                state_q;
  logic                  route_q;
  logic                  busy_q;
  logic                  valid_0_q, valid_1_q;
  logic                  last_0_q, last_1_q;
  logic [DATA_WIDTH-1:0] data_0_q, data_1_q;

  logic route_eff;
  logic slot_free_0, slot_free_1;
  logic ready;
  logic accept;
  logic load_0, load_1;
  logic drain_0, drain_1;

  // The head beat follows i_sel directly; later beats use the locked route.
  assign route_eff   = (state_q == IN_PKT) ? route_q : bus.i_sel;
  assign slot_free_0 = !valid_0_q || bus.i_ready_0;
  assign slot_free_1 = !valid_1_q || bus.i_ready_1;
  assign ready       = route_eff ? slot_free_1 : slot_free_0;
  assign accept      = bus.i_valid && ready;
  assign load_0      = accept && !route_eff;
  assign load_1      = accept && route_eff;
  assign drain_0     = valid_0_q && bus.i_ready_0;
  assign drain_1     = valid_1_q && bus.i_ready_1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      route_q   <= 1'b0;
      busy_q    <= 1'b0;
      valid_0_q <= 1'b0;
      valid_1_q <= 1'b0;
      last_0_q  <= 1'b0;
      last_1_q  <= 1'b0;
      data_0_q  <= '0;
      data_1_q  <= '0;
    end else begin
      // Slot k only reloads when free, so its data/last stay stable while stalled.
      if (load_0) begin
        valid_0_q <= 1'b1;
        data_0_q  <= bus.i_data;
        last_0_q  <= bus.i_last;
      end else if (drain_0) begin
        valid_0_q <= 1'b0;
      end

      if (load_1) begin
        valid_1_q <= 1'b1;
        data_1_q  <= bus.i_data;
        last_1_q  <= bus.i_last;
      end else if (drain_1) begin
        valid_1_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (accept && !bus.i_last) begin
            state_q <= IN_PKT;
            route_q <= bus.i_sel;
            busy_q  <= 1'b1;
          end
        end
        IN_PKT: begin
          if (accept && bus.i_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready   = ready;
  assign bus.o_valid_0 = valid_0_q;
  assign bus.o_valid_1 = valid_1_q;
  assign bus.o_data_0  = data_0_q;
  assign bus.o_data_1  = data_1_q;
  assign bus.o_last_0  = last_0_q;
  assign bus.o_last_1  = last_1_q;
  assign o_busy        = busy_q;

`ifdef STREAM_DEMUX_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_0_q, cnt_1_q;

  // A packet counts as complete when its last beat leaves the slot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_0_q <= '0;
      cnt_1_q <= '0;
    end else begin
      if (drain_0 && last_0_q) cnt_0_q <= cnt_0_q + 1'b1;
      if (drain_1 && last_1_q) cnt_1_q <= cnt_1_q + 1'b1;
    end
  end

  assign o_cnt_0 = cnt_0_q;
  assign o_cnt_1 = cnt_1_q;
`else
  assign o_cnt_0 = '0;
  assign o_cnt_1 = '0;
`endif

endmodule

// File: tb/tb_stream_demux1to2.sv
// tb/tb_stream_demux1to2.sv - directed self-checking bench for stream_demux1to2
module tb_stream_demux1to2;
  localparam int DW = 8;
  localparam int CW = 2;

  logic          clk;
  logic          rst;
  logic          busy;
  logic [CW-1:0] cnt_0, cnt_1;
  int            checks;
  int            errors;

  stream_demux1to2_if #(.DATA_WIDTH(DW)) bus ();

  stream_demux1to2 #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .bus     (bus),
    .o_busy  (busy),
    .o_cnt_0 (cnt_0),
    .o_cnt_1 (cnt_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l, input logic s);
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_last  = l;
    bus.i_sel   = s;
  endtask

  initial begin
    logic [CW-1:0] exp_cnt;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    bus.i_ready_0 = 1'b1;
    bus.i_ready_1 = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_valid_0", 16'(bus.o_valid_0), 16'h0);
    chk("rst_valid_1", 16'(bus.o_valid_1), 16'h0);
    chk("rst_busy",    16'(busy),          16'h0);
    chk("rst_data_0",  16'(bus.o_data_0),  16'h0);
    chk("rst_cnt_1",   16'(cnt_1),         16'h0);
    rst = 1'b0;
    tick();

    // Single-beat packet to output 1
    drive(1'b1, 8'hA5, 1'b1, 1'b1);
    #1 chk("sb_ready", 16'(bus.o_ready), 16'h1);
    tick();
    chk("sb_valid_1", 16'(bus.o_valid_1), 16'h1);
    chk("sb_data_1",  16'(bus.o_data_1),  16'hA5);
    chk("sb_last_1",  16'(bus.o_last_1),  16'h1);
    chk("sb_valid_0", 16'(bus.o_valid_0), 16'h0);
    chk("sb_busy",    16'(busy),          16'h0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("sb_drained", 16'(bus.o_valid_1), 16'h0);

    // Route lock: 4 beats with i_sel toggling after the head
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h10 + i), (i == 3), i[0]);
      tick();
      chk("lock_valid_0", 16'(bus.o_valid_0), 16'h1);
      chk("lock_data_0",  16'(bus.o_data_0),  16'(8'h10 + i));
      chk("lock_last_0",  16'(bus.o_last_0),  16'(i == 3));
      chk("lock_valid_1", 16'(bus.o_valid_1), 16'h0);
      chk("lock_busy",    16'(busy),          16'(i != 3));
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("lock_drained", 16'(bus.o_valid_0), 16'h0);

    // Backpressure on output 0 for 3 cycles
    bus.i_ready_0 = 1'b0;
    drive(1'b1, 8'h30, 1'b0, 1'b0);
    #1 chk("bp_ready_empty", 16'(bus.o_ready), 16'h1);
    tick();
    chk("bp_data_head", 16'(bus.o_data_0), 16'h30);
    drive(1'b1, 8'h31, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready_full", 16'(bus.o_ready), 16'h0);
      tick();
      chk("bp_data_stable",  16'(bus.o_data_0),  16'h30);
      chk("bp_valid_stable", 16'(bus.o_valid_0), 16'h1);
    end
    bus.i_ready_0 = 1'b1;
    #1 chk("bp_ready_release", 16'(bus.o_ready), 16'h1);
    tick();
    chk("bp_data_1", 16'(bus.o_data_0), 16'h31);
    drive(1'b1, 8'h32, 1'b1, 1'b1);
    tick();
    chk("bp_data_2", 16'(bus.o_data_0), 16'h32);
    chk("bp_last_2", 16'(bus.o_last_0), 16'h1);
    chk("bp_busy",   16'(busy),         16'h0);
    chk("bp_valid_1", 16'(bus.o_valid_1), 16'h0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("bp_drained", 16'(bus.o_valid_0), 16'h0);

    // Independent outputs: output 1 stalled holding 0x77
    bus.i_ready_1 = 1'b0;
    drive(1'b1, 8'h77, 1'b1, 1'b1);
    tick();
    chk("ind_hold_valid", 16'(bus.o_valid_1), 16'h1);
    drive(1'b1, 8'h22, 1'b1, 1'b0);
    #1 chk("ind_ready_0", 16'(bus.o_ready), 16'h1);
    tick();
    chk("ind_valid_0", 16'(bus.o_valid_0), 16'h1);
    chk("ind_data_0",  16'(bus.o_data_0),  16'h22);
    chk("ind_data_1",  16'(bus.o_data_1),  16'h77);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    #1 chk("ind_ready_no_valid", 16'(bus.o_ready), 16'h0);
    tick();
    chk("ind_drained_0", 16'(bus.o_valid_0), 16'h0);
    chk("ind_held_1",    16'(bus.o_valid_1), 16'h1);
    chk("ind_held_d1",   16'(bus.o_data_1),  16'h77);

    // Mid-packet reset with output 0 occupied
    bus.i_ready_0 = 1'b0;
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    tick();
    chk("pre_rst_busy", 16'(busy), 16'h1);
    rst = 1'b1;
    #1;
    chk("mrst_valid_0", 16'(bus.o_valid_0), 16'h0);
    chk("mrst_valid_1", 16'(bus.o_valid_1), 16'h0);
    chk("mrst_busy",    16'(busy),          16'h0);
    chk("mrst_data_0",  16'(bus.o_data_0),  16'h0);
    chk("mrst_data_1",  16'(bus.o_data_1),  16'h0);
    chk("mrst_cnt_0",   16'(cnt_0),         16'h0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    bus.i_ready_0 = 1'b1;
    bus.i_ready_1 = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Five single-beat packets to output 1
    exp_cnt = '0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'(8'h60 + k), 1'b1, 1'b1);
      tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
`ifdef STREAM_DEMUX_CNT_EN
      exp_cnt = exp_cnt + 1'b1;
`endif
      chk("cnt_1", 16'(cnt_1), 16'(exp_cnt));
      chk("cnt_0", 16'(cnt_0), 16'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
